ifid_stall_ctrl: RTL

Pipeline-control block that acts on the load-use `stall` from the hazard detection unit and on the branch-flush and memory-busy requests. It owns the IF/ID pipeline register, the PC write enable and the ID/EX bubble-insert control. It sits between the fetch stage and the decode stage of the 5-stage 16-bit core. It also keeps saturating event counters and a sticky protocol-error flag for verification and performance analysis.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 35 +++
 rtl/ifid_stall_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline-control definitions for the 16-bit core.
//                Holds the NOP encoding, the IW/PCW defaults and the
//                cycle-class enum with its priority classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Default datapath widths of the 5-stage 16-bit core
  localparam int IW_DEF  = 16;
  localparam int PCW_DEF = 16;

  // Instruction placed into IF/ID on flush and reset
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Per-cycle pipeline class, also kept registered for debug
  typedef enum logic [1:0] {
    CLS_RUN    = 2'd0,
    CLS_STALL  = 2'd1,
    CLS_FLUSH  = 2'd2,
    CLS_FREEZE = 2'd3
  } cls_t;

  // Priority: memory busy beats load-use stall, which beats branch flush.
  // A stalled branch is not resolved yet, so its flush must be dropped.
  function automatic cls_t classify(input logic busy,
                                    input logic stall,
                                    input logic flush);
    cls_t c;
    if (busy)       c = CLS_FREEZE;
    else if (stall) c = CLS_STALL;
    else if (flush) c = CLS_FLUSH;
    else            c = CLS_RUN;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that increments on 'inc' and sticks at its
//                all-ones maximum instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] q
);

  localparam logic [CW-1:0] C_MAX = {CW{1'b1}};

  logic at_max;

  assign at_max = (q == C_MAX);

  // Count events, holding at the maximum so long runs never alias to small values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifid_stall_ctrl.sv
// ============================================================================
//  Module      : ifid_stall_ctrl
//  Description : IF/ID pipeline register and fetch/decode control. Resolves
//                memory-busy, load-use stall and branch flush into one cycle
//                class, drives PC enable / global freeze / ID-EX bubble, and
//                keeps saturating event counters plus a sticky error flag
//                for stalls that last longer than one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int              IW  = IW_DEF,
  parameter int              PCW = PCW_DEF,
  parameter int              CW  = 16,
  parameter logic [IW-1:0]   NOP = IW'(NOP_INSTR)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall_in,
  input  logic           flush_in,
  input  logic           mem_busy,
  input  logic [IW-1:0]  if_instr,
  input  logic [PCW-1:0] if_pc,
  output logic           pc_we,
  output logic           freeze,
  output logic           idex_bubble,
  output logic [IW-1:0]  ifid_instr,
  output logic [PCW-1:0] ifid_pc,
  output logic           ifid_valid,
  output logic [CW-1:0]  cnt_stall,
  output logic [CW-1:0]  cnt_flush,
  output logic [CW-1:0]  cnt_freeze,
  output logic           proto_err
);

  cls_t state;       // class of the previous cycle
  cls_t cls_next;    // class of the current cycle
  logic prev_stall;  // last non-FREEZE cycle before 'state' was STALL
  logic prev_stall_eff;
  logic is_run;
  logic is_stall;
  logic is_flush;
  logic is_freeze;

  // --------------------------------------------------------------------------
  // Cycle classification (next-state logic)
  // --------------------------------------------------------------------------

  // Classify the current cycle from the live request inputs
  always_comb begin
    cls_next = classify(mem_busy, stall_in, flush_in);
  end

  assign is_run    = (cls_next == CLS_RUN);
  assign is_stall  = (cls_next == CLS_STALL);
  assign is_flush  = (cls_next == CLS_FLUSH);
  assign is_freeze = (cls_next == CLS_FREEZE);

  // --------------------------------------------------------------------------
  // Registered class
  // --------------------------------------------------------------------------

  // Remember the class of each cycle for debug and stall-length checking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLS_RUN;
    end else begin
      state <= cls_next;
    end
  end

  // --------------------------------------------------------------------------
  // Control outputs
  // --------------------------------------------------------------------------

  // Same-cycle control; reset parks the core with the PC held and all frozen
  always_comb begin
    pc_we       = 1'b0;
    freeze      = 1'b1;
    idex_bubble = 1'b0;
    if (rst_n) begin
      pc_we       = is_run || is_flush;
      freeze      = is_freeze;
      idex_bubble = is_stall;
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID pipeline register
  // --------------------------------------------------------------------------

  // Load on RUN, squash on FLUSH, hold on STALL and FREEZE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr <= NOP;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else if (is_run) begin
      ifid_instr <= if_instr;
      ifid_pc    <= if_pc;
      ifid_valid <= 1'b1;
    end else if (is_flush) begin
      ifid_instr <= NOP;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stall-length protocol check
  // --------------------------------------------------------------------------

  // Whether the most recent non-FREEZE cycle before now was a STALL:
  // FREEZE cycles are transparent, so fall back to the remembered value.
  assign prev_stall_eff = (state == CLS_FREEZE) ? prev_stall
                                                : (state == CLS_STALL);

  // Carry the last non-FREEZE stall status forward across freeze windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      prev_stall <= prev_stall_eff;
    end
  end

  // A load-use stall lasts exactly one cycle; a back-to-back stall is an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if (is_stall && prev_stall_eff) begin
      proto_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Event counters
  // --------------------------------------------------------------------------

  logic [2:0]    cnt_inc;
  logic [CW-1:0] cnt_q [3];

  assign cnt_inc = {is_freeze, is_flush, is_stall};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(
        .CW (CW)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc[gi]),
        .q     (cnt_q[gi])
      );
    end
  endgenerate

  assign cnt_stall  = cnt_q[0];
  assign cnt_flush  = cnt_q[1];
  assign cnt_freeze = cnt_q[2];

endmodule

`default_nettype wire
